// File: rtl/ahb_dp_route_mux_pkg.sv
// rtl/ahb_dp_route_mux_pkg.sv - shared types and helpers for the data-phase route mux
package ahb_dp_route_mux_pkg;

    typedef enum logic [1:0] {
        DPM_IDLE,
        DPM_ROUTE,
        DPM_ERR1,
        DPM_ERR2
    } dpm_state_e;

    // Widest select vector the helper accepts; callers zero-extend into it.
    localparam int DPM_MAX_CH = 64;

    function automatic logic is_onehot(input logic [DPM_MAX_CH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ahb_dp_route_mux_if.sv
// rtl/ahb_dp_route_mux_if.sv - select/payload/error-response bundle for the route mux
interface ahb_dp_route_mux_if #(
    parameter int CHANNEL_NUM = 2,
    parameter int PAYLOAD     = 34,
    parameter int ERR_CNT_W   = 8
);
    logic [CHANNEL_NUM-1:0]              addr_sel;
    logic                                addr_valid;
    logic                                hready_in;
    logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in;
    logic [PAYLOAD-1:0]                  payload_out;
    logic [CHANNEL_NUM-1:0]              dp_sel;
    logic                                err_hready;
    logic                                err_hresp;
    logic                                err_active;
    logic [ERR_CNT_W-1:0]                err_count;

    modport master (
        output addr_sel, addr_valid, hready_in, payload_in,
        input  payload_out, dp_sel, err_hready, err_hresp, err_active, err_count
    );

    modport slave (
        input  addr_sel, addr_valid, hready_in, payload_in,
        output payload_out, dp_sel, err_hready, err_hresp, err_active, err_count
    );
endinterface

// File: rtl/ahb_onehot_to_idx.sv
// rtl/ahb_onehot_to_idx.sv - one-hot select to binary index with exactly-one-set flag
module ahb_onehot_to_idx
    import ahb_dp_route_mux_pkg::*;
#(
    parameter int N    = 2,
    parameter int IW   = $clog2(N)
) (
    input  logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // OR of set-bit positions; only meaningful when valid is high.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                idx = idx | IW'(i);
            end
        end
    end

    assign valid = is_onehot(DPM_MAX_CH'(sel));

endmodule

// File: rtl/ahb_dp_route_mux.sv
// rtl/ahb_dp_route_mux.sv - AHB data-phase payload mux with built-in decode-error response
module ahb_dp_route_mux
    import ahb_dp_route_mux_pkg::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int PAYLOAD     = 34,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_dp_route_mux_if.slave    bus
);

    localparam int IDX_W = $clog2(CHANNEL_NUM);

    dpm_state_e             state_q, state_d;
    logic [CHANNEL_NUM-1:0] dp_sel_q, dp_sel_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   capture;
    logic [IDX_W-1:0]       dp_idx;
    logic                   dp_valid;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= DPM_IDLE;
            dp_sel_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dp_sel_q  <= dp_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // ERR1 is the non-ready half of the error response: no address phase can complete there.
    always_comb begin
        state_d   = state_q;
        dp_sel_d  = dp_sel_q;
        err_cnt_d = err_cnt_q;
        capture   = 1'b0;

        case (state_q)
            DPM_ERR1: state_d = DPM_ERR2;
            default:  capture = bus.hready_in;
        endcase

        if (capture) begin
            if (!bus.addr_valid) begin
                state_d  = DPM_IDLE;
                dp_sel_d = '0;
            end else if (is_onehot(DPM_MAX_CH'(bus.addr_sel))) begin
                state_d  = DPM_ROUTE;
                dp_sel_d = bus.addr_sel;
            end else begin
                state_d  = DPM_ERR1;
                dp_sel_d = '0;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    ahb_onehot_to_idx #(
        .N  (CHANNEL_NUM),
        .IW (IDX_W)
    ) u_dp_idx (
        .sel   (dp_sel_q),
        .idx   (dp_idx),
        .valid (dp_valid)
    );

    // Only the owning channel is ever read, so unselected inputs cannot leak through.
    always_comb begin
        bus.payload_out = '0;
        if (state_q == DPM_ROUTE && dp_valid) begin
            bus.payload_out = bus.payload_in[dp_idx];
        end
    end

    assign bus.dp_sel     = dp_sel_q;
    assign bus.err_hready = (state_q != DPM_ERR1);
    assign bus.err_hresp  = (state_q == DPM_ERR1) || (state_q == DPM_ERR2);
    assign bus.err_active = (state_q == DPM_ERR1) || (state_q == DPM_ERR2);
    assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_ahb_dp_route_mux.sv
// tb/tb_ahb_dp_route_mux.sv - directed table-driven bench for ahb_dp_route_mux
module tb_ahb_dp_route_mux;

    localparam int CH = 4;
    localparam int PW = 34;
    localparam int CW = 2;

    logic HCLK = 1'b0;
    logic HRESET;

    always #5 HCLK = ~HCLK;

    ahb_dp_route_mux_if #(.CHANNEL_NUM(CH), .PAYLOAD(PW), .ERR_CNT_W(CW)) bus ();

    ahb_dp_route_mux #(
        .CHANNEL_NUM (CH),
        .PAYLOAD     (PW),
        .ERR_CNT_W   (CW)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    typedef struct {
        logic          rst;
        logic [CH-1:0] sel;
        logic          vld;
        logic          rdy;
        logic [CH-1:0] e_dp;
        int            e_ch;
        logic          e_hready;
        logic          e_hresp;
        logic          e_active;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t          vecs[$];
    int            total = 0;
    int            bad   = 0;
    logic [PW-1:0] pl_val [CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [CH-1:0] sel, input logic vld, input logic rdy);
        HRESET         = rst;
        bus.addr_sel   = sel;
        bus.addr_valid = vld;
        bus.hready_in  = rdy;
        @(posedge HCLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [CH-1:0] dp, input int ch,
                              input logic hr, input logic hresp, input logic act,
                              input logic [CW-1:0] cnt);
        logic [PW-1:0] pe;
        pe = (ch < 0) ? '0 : pl_val[ch];
        chk({tag, ".dp_sel"},      64'(bus.dp_sel),      64'(dp));
        chk({tag, ".payload_out"}, 64'(bus.payload_out), 64'(pe));
        chk({tag, ".err_hready"},  64'(bus.err_hready),  64'(hr));
        chk({tag, ".err_hresp"},   64'(bus.err_hresp),   64'(hresp));
        chk({tag, ".err_active"},  64'(bus.err_active),  64'(act));
        chk({tag, ".err_count"},   64'(bus.err_count),   64'(cnt));
    endtask

    task automatic add(input logic rst, input logic [CH-1:0] sel, input logic vld, input logic rdy,
                       input logic [CH-1:0] dp, input int ch, input logic hr, input logic hresp,
                       input logic act, input logic [CW-1:0] cnt);
        vec_t v;
        v.rst = rst; v.sel = sel; v.vld = vld; v.rdy = rdy;
        v.e_dp = dp; v.e_ch = ch; v.e_hready = hr; v.e_hresp = hresp;
        v.e_active = act; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            pl_val[i]         = {2'b10, 32'hC0DE_0000 + 32'(i) * 32'h1111};
            bus.payload_in[i] = pl_val[i];
        end
        HRESET         = 1'b1;
        bus.addr_sel   = '0;
        bus.addr_valid = 1'b0;
        bus.hready_in  = 1'b1;

        //   rst  sel      vld  rdy    dp       ch  hr  hrsp act cnt
        add(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100,  2, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001,  0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0001,  0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0001,  0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0110, 1'b1, 1'b0, 4'b0001,  0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000,  3, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0110, 1'b1, 1'b1, 4'b0000, -1, 1'b0, 1'b1, 1'b1, 2'd1);
        add(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 1'b1, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, -1, 1'b0, 1'b1, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, -1, 1'b1, 1'b1, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd2);
        add(1'b0, 4'b1100, 1'b1, 1'b1, 4'b0000, -1, 1'b0, 1'b1, 1'b1, 2'd3);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, -1, 1'b1, 1'b1, 1'b1, 2'd3);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 1'b1, 1'b1, 2'd3);
        add(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010,  1, 1'b1, 1'b0, 1'b0, 2'd3);
        add(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, -1, 1'b0, 1'b1, 1'b1, 2'd3);
        add(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100,  2, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].sel, vecs[i].vld, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].e_dp, vecs[i].e_ch, vecs[i].e_hready,
                       vecs[i].e_hresp, vecs[i].e_active, vecs[i].e_cnt);
        end

        // Five back-to-back decode errors: counter saturates, every response stays two cycles.
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        expect_out("sat_rst", 4'b0000, -1, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            logic [CW-1:0] ec;
            ec = (k > 3) ? 2'd3 : CW'(k);
            drive(1'b0, 4'b1010, 1'b1, 1'b1);
            expect_out($sformatf("sat%0d_err1", k), 4'b0000, -1, 1'b0, 1'b1, 1'b1, ec);
            drive(1'b0, 4'b0000, 1'b0, 1'b1);
            expect_out($sformatf("sat%0d_err2", k), 4'b0000, -1, 1'b1, 1'b1, 1'b1, ec);
        end

        // Payload follows the selected channel combinationally and ignores the others.
        drive(1'b0, 4'b0010, 1'b1, 1'b1);
        expect_out("live_route", 4'b0010, 1, 1'b1, 1'b0, 1'b0, 2'd3);
        pl_val[1]         = 34'h1_2345_6789;
        bus.payload_in[1] = pl_val[1];
        #1;
        chk("live_sel_change", 64'(bus.payload_out), 64'(pl_val[1]));
        bus.payload_in[0] = 34'h3_FFFF_FFFF;
        bus.payload_in[3] = 34'h0_0BAD_0BAD;
        #1;
        chk("live_unsel_change", 64'(bus.payload_out), 64'(pl_val[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
